// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, handshake FSM state encoding and the result flag bundle shared by alu_pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SLL  = 4'h3;
    localparam logic [3:0] OP_SRL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hC;

    // Handshake FSM: HOLD parks a finished product until the output slot frees.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic zero;
        logic cout;
        logic overflow;
        logic negative;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per clock.
// Latency: WIDTH edges after start; 'last' is high during the cycle whose edge completes the product.
// Backpressure: none; the caller must not pulse start while an operation is still counting.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   s,
    input  logic [WIDTH-1:0]   t,
    output logic               last,
    output logic [2*WIDTH-1:0] prod_nxt,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Load operands on start, otherwise retire one multiplier bit per cycle until the count expires.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, s};
            mplier_d = t;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    // Iteration state; reset abandons any product in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last     = (cnt_q == CW'(1));
    assign prod_nxt = acc_d;
    assign prod     = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and flags; iterative MUL when ALU_MUL_EN is defined.
// Latency: 1 edge for single-cycle ops; WIDTH edges for MUL (longer if the output slot is still occupied).
// Backpressure: in_ready drops while the result slot is held (out_valid && !out_ready) or a MUL is in flight.
module alu_pipe #(
    parameter int WIDTH = 32    // operand width, power of two and at least 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             err
);

    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] op_res;
    logic             op_legal;
    flags_t           op_flags;

    logic             slot_free;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    flags_t           load_flags;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    assign shamt   = t[SHW-1:0];
    assign add_sum = {1'b0, s} + {1'b0, t};
    // s + ~t + 1 gives the borrow-free carry: set when s >= t unsigned.
    assign sub_sum = {1'b0, s} + {1'b0, ~t} + (WIDTH+1)'(1);

    // Single-cycle operation decode; illegal opcodes report err with every other flag clear.
    always_comb begin
        op_res   = '0;
        op_flags = '0;
        op_legal = 1'b1;
        case (control)
            OP_AND:  op_res = s & t;
            OP_OR:   op_res = s | t;
            OP_NOR:  op_res = ~(s | t);
            OP_SLL:  op_res = s << shamt;
            OP_SRL:  op_res = s >> shamt;
            OP_SRA:  op_res = $signed(s) >>> shamt;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(s) < $signed(t))};
            OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (s < t)};
            OP_ADD: begin
                op_res            = add_sum[MSB:0];
                op_flags.cout     = add_sum[WIDTH];
                op_flags.overflow = (s[MSB] == t[MSB]) && (add_sum[MSB] != s[MSB]);
            end
            OP_SUB: begin
                op_res            = sub_sum[MSB:0];
                op_flags.cout     = sub_sum[WIDTH];
                op_flags.overflow = (s[MSB] != t[MSB]) && (sub_sum[MSB] != s[MSB]);
            end
`ifdef ALU_MUL_EN
            // The product comes from the multiplier, never from this path.
            OP_MUL:  op_res = '0;
`endif
            default: op_legal = 1'b0;
        endcase
        if (op_legal) begin
            op_flags.zero     = (op_res == '0);
            op_flags.negative = op_res[MSB];
        end else begin
            op_flags.err = 1'b1;
        end
    end

    assign slot_free = !out_valid_q || out_ready;

`ifdef ALU_MUL_EN
    state_e             state_q, state_d;
    logic               mul_start;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod_nxt;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_src;
    logic [WIDTH-1:0]   mul_res;
    flags_t             mul_flags;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (mul_start),
        .s        (s),
        .t        (t),
        .last     (mul_last),
        .prod_nxt (mul_prod_nxt),
        .prod     (mul_prod)
    );

    assign in_ready = reset_n && (state_q == IDLE) && slot_free;

    // Product flags: the completing edge uses the adder output, HOLD uses the settled accumulator.
    always_comb begin
        mul_src            = (state_q == HOLD) ? mul_prod : mul_prod_nxt;
        mul_res            = mul_src[MSB:0];
        mul_flags          = '0;
        mul_flags.cout     = |mul_src[2*WIDTH-1:WIDTH];
        mul_flags.overflow = |mul_src[2*WIDTH-1:WIDTH];
        mul_flags.zero     = (mul_res == '0);
        mul_flags.negative = mul_res[MSB];
    end
`else
    assign in_ready = reset_n && slot_free;
`endif

    assign accept = in_valid && in_ready;

    // Handshake FSM: decide whether the output registers load this edge and from which source.
    always_comb begin
        load       = 1'b0;
        load_res   = op_res;
        load_flags = op_flags;
`ifdef ALU_MUL_EN
        state_d    = state_q;
        mul_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (control == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    if (slot_free) begin
                        load       = 1'b1;
                        load_res   = mul_res;
                        load_flags = mul_flags;
                        state_d    = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_res   = mul_res;
                    load_flags = mul_flags;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        load = accept;
`endif
    end

    // Output slot: a load always wins over consumption on the same edge.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (load) begin
            out_valid_d = 1'b1;
            result_d    = load_res;
            flags_d     = load_flags;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

`ifdef ALU_MUL_EN
    // FSM state register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = flags_q.zero;
    assign cout      = flags_q.cout;
    assign overflow  = flags_q.overflow;
    assign negative  = flags_q.negative;
    assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=32), directed vectors plus random scoreboard.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: exercised through random and directed out_ready patterns.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] s = '0;
    logic [31:0] t = '0;
    logic [3:0]  control = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero, cout, overflow, negative, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic z;
        logic c;
        logic v;
        logic n;
        logic e;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    alu_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .t         (t),
        .control   (control),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .negative  (negative),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] r, input logic z, input logic c,
                                input logic v, input logic n, input logic e);
        exp_t x;
        x.res = r; x.z = z; x.c = c; x.v = v; x.n = n; x.e = e;
        return x;
    endfunction

    function automatic exp_t obs();
        return mk(result, zero, cout, overflow, negative, err);
    endfunction

    // Reference: arithmetic in 64 bits, overflow as "true signed result out of 32-bit range".
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t            r;
        longint          sa, sb, sr;
        longint unsigned ua, ub, ur;
        logic [4:0]      sh;
        bit              legal;
        r     = '0;
        legal = 1'b1;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = {32'd0, a};
        ub    = {32'd0, b};
        sh    = b[4:0];
        case (op)
            4'h0: r.res = a & b;
            4'h1: r.res = a | b;
            4'h2: begin
                ur    = ua + ub;
                r.res = ur[31:0];
                r.c   = (ur > 64'hFFFF_FFFF);
                sr    = sa + sb;
                r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h3: r.res = a << sh;
            4'h4: r.res = a >> sh;
            4'h5: begin
                sr    = sa >>> sh;
                r.res = sr[31:0];
            end
            4'h6: begin
                r.res = a - b;
                r.c   = (ua >= ub);
                sr    = sa - sb;
                r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h7: r.res = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'h8: begin
                ur    = ua * ub;
                r.res = ur[31:0];
                r.c   = (ur > 64'hFFFF_FFFF);
                r.v   = r.c;
            end
`endif
            4'h9: r.res = (ua < ub) ? 32'd1 : 32'd0;
            4'hC: r.res = ~(a | b);
            default: legal = 1'b0;
        endcase
        if (legal) begin
            r.z = (r.res == 32'd0);
            r.n = r.res[31];
        end else begin
            r = '0;
            r.e = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'hFFFF_FFFF; corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h1;
        if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    // A single-cycle opcode (never MUL).
    function automatic logic [3:0] rand_fast_op();
        logic [3:0] op;
        op = 4'($urandom_range(15));
        if (op == 4'h8) op = 4'h2;
        return op;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    // Offer one op with out_ready high; capture acceptance and the registered result one edge later.
    task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic acc, output logic vld, output exp_t o);
        @(negedge clk);
        in_valid = 1'b1; control = op; s = a; t = b; out_ready = 1'b1;
        #1 acc = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 vld = out_valid;
        o = obs();
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (obs() !== exp_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs(), exp_t'(0)); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_directed();
        vec_t v[$];
        vec_t x;
        logic acc, vld;
        exp_t o;
        x.op = 4'h2; x.a = 32'h7FFF_FFFF; x.b = 32'h1; x.e = mk(32'h8000_0000, 0, 0, 1, 1, 0); v.push_back(x);
        x.op = 4'h2; x.a = 32'hFFFF_FFFF; x.b = 32'h1; x.e = mk(32'h0, 1, 1, 0, 0, 0);         v.push_back(x);
        x.op = 4'h6; x.a = 32'd5;         x.b = 32'd7; x.e = mk(32'hFFFF_FFFE, 0, 0, 0, 1, 0); v.push_back(x);
        x.op = 4'h6; x.a = 32'd7;         x.b = 32'd5; x.e = mk(32'h2, 0, 1, 0, 0, 0);         v.push_back(x);
        x.op = 4'h6; x.a = 32'h8000_0000; x.b = 32'h1; x.e = mk(32'h7FFF_FFFF, 0, 1, 1, 0, 0); v.push_back(x);
        x.op = 4'h7; x.a = 32'hFFFF_FFFF; x.b = 32'h1; x.e = mk(32'h1, 0, 0, 0, 0, 0);         v.push_back(x);
        x.op = 4'h9; x.a = 32'hFFFF_FFFF; x.b = 32'h1; x.e = mk(32'h0, 1, 0, 0, 0, 0);         v.push_back(x);
        x.op = 4'h5; x.a = 32'h8000_0000; x.b = 32'd4; x.e = mk(32'hF800_0000, 0, 0, 0, 1, 0); v.push_back(x);
        x.op = 4'h4; x.a = 32'h8000_0000; x.b = 32'd4; x.e = mk(32'h0800_0000, 0, 0, 0, 0, 0); v.push_back(x);
        x.op = 4'h3; x.a = 32'h1;         x.b = 32'h21; x.e = mk(32'h2, 0, 0, 0, 0, 0);        v.push_back(x);
        x.op = 4'hC; x.a = 32'h0;         x.b = 32'h0; x.e = mk(32'hFFFF_FFFF, 0, 0, 0, 1, 0); v.push_back(x);
        x.op = 4'hF; x.a = 32'h1234;      x.b = 32'h5; x.e = mk(32'h0, 0, 0, 0, 0, 1);         v.push_back(x);
`ifndef ALU_MUL_EN
        x.op = 4'h8; x.a = 32'h3;         x.b = 32'h5; x.e = mk(32'h0, 0, 0, 0, 0, 1);         v.push_back(x);
`endif
        foreach (v[i]) begin
            run_single(v[i].op, v[i].a, v[i].b, acc, vld, o);
            n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL directed_accept[%0d]: got %b expected 1", i, acc); end
            n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL directed_valid[%0d]: got %b expected 1", i, vld); end
            n_checks++; if (o !== v[i].e) begin n_fail++; $display("FAIL directed[%0d] op %h: got %h expected %h", i, v[i].op, o, v[i].e); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t prev;
        idle(2);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (i < 10);
            control   = rand_fast_op();
            s         = rand_operand();
            t         = rand_operand();
            #1;
            if (i < 10) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            end
            if (i > 0) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid); end
                n_checks++; if (obs() !== prev) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, obs(), prev); end
            end
            prev = model(control, s, t);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t ea, eb;
        idle(2);
        ea = model(4'h2, 32'd3, 32'd4);
        eb = model(4'h6, 32'd10, 32'd3);
        @(negedge clk);
        in_valid = 1'b1; control = 4'h2; s = 32'd3; t = 32'd4; out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept: got %b expected 1", in_ready); end
        @(negedge clk);
        control = 4'h6; s = 32'd10; t = 32'd3;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low[%0d]: got %b expected 0", c, in_ready); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, out_valid); end
            n_checks++; if (obs() !== ea) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h expected %h", c, obs(), ea); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_accept: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b expected 1", out_valid); end
        n_checks++; if (obs() !== eb) begin n_fail++; $display("FAIL bp_second_result: got %h expected %h", obs(), eb); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t exp_v, held;
        logic hold_prev;
        logic [3:0] op;
        int drain;
        idle(2);
        hold_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            op = 4'($urandom_range(15));
            if (op == 4'h8 && $urandom_range(5) != 0) op = 4'h6;
            in_valid  = ($urandom_range(3) != 0);
            control   = op;
            s         = rand_operand();
            t         = rand_operand();
            out_ready = ($urandom_range(2) != 0);
            #1;
            if (hold_prev) begin
                n_checks++; if (out_valid !== 1'b1 || obs() !== held) begin n_fail++; $display("FAIL rand_stable[%0d]: got v=%b %h expected v=1 %h", cyc, out_valid, obs(), held); end
            end
            if (out_valid && out_ready) begin
                exp_v = (q.size() > 0) ? q.pop_front() : exp_t'(0);
                n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", cyc, obs(), exp_v); end
            end
            if (in_valid && in_ready) q.push_back(model(control, s, t));
            hold_prev = out_valid && !out_ready;
            held = obs();
        end
        drain = 0;
        while ((q.size() > 0 || out_valid) && drain < 100) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                exp_v = (q.size() > 0) ? q.pop_front() : exp_t'(0);
                n_checks++; if (obs() !== exp_v) begin n_fail++; $display("FAIL rand_drain: got %h expected %h", obs(), exp_v); end
            end
            drain++;
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d pending expected 0", q.size()); end
    endtask

    task automatic test_reset_midstream();
        idle(2);
        @(negedge clk);
        in_valid = 1'b1; control = 4'h1; s = 32'hA5; t = 32'h5A; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_loaded: got %b expected 1", out_valid); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || obs() !== exp_t'(0)) begin n_fail++; $display("FAIL rst_mid_clear: got v=%b %h expected v=0 0", out_valid, obs()); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        exp_t e;
        int edges;
        bit seen;
        logic [31:0] ra, rb;
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin ra = 32'h0001_0000; rb = 32'h0001_0000; end
            else begin ra = $urandom; rb = (k == 1) ? 32'h0000_1234 : $urandom; end
            e = model(4'h8, ra, rb);
            if (k == 0) e = mk(32'h0, 1, 1, 1, 0, 0);
            idle(2);
            @(negedge clk);
            in_valid = 1'b1; control = 4'h8; s = ra; t = rb; out_ready = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_accept[%0d]: got %b expected 1", k, in_ready); end
            @(posedge clk);
            edges = 0;
            seen  = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid) begin seen = 1'b1; break; end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy_in_ready[%0d]: got %b expected 0", c, in_ready); end
                @(posedge clk);
                edges++;
            end
            n_checks++; if (!seen || edges != 32) begin n_fail++; $display("FAIL mul_latency[%0d]: got seen=%0d edges=%0d expected 32", k, seen, edges); end
            n_checks++; if (obs() !== e) begin n_fail++; $display("FAIL mul_result[%0d]: got %h expected %h", k, obs(), e); end
        end
    endtask

    task automatic test_mul_reset();
        bit stale;
        idle(2);
        @(negedge clk);
        in_valid = 1'b1; control = 4'h8; s = 32'h1234_5678; t = 32'h9ABC_DEF0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_rst_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_rst_in_ready: got %b expected 1", in_ready); end
        stale = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1 if (out_valid) stale = 1'b1;
        end
        n_checks++; if (stale) begin n_fail++; $display("FAIL mul_rst_stale: got out_valid=1 expected 0"); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_reset();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked ALU: the next generation of the team's single-cycle 32-bit ALU. It takes one operation per accepted valid/ready transfer and returns a registered result with zero/carry/overflow/negative/error flags. It adds shifts, unsigned compare, correct signed overflow, output backpressure, and an optional iterative multiplier. It sits between decode/issue and writeback in the MIPS datapath.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready at a rising edge.
- s, t  in  WIDTH  operands.
- control  in  4  opcode.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer takes the result when out_valid && out_ready.
- result  out  WIDTH  operation result.
- zero, cout, overflow, negative, err  out  1 each  result flags.

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 5 SRA, 6 SUB.
  - 7 SLT (signed), 8 MUL (macro only), 9 SLTU, C NOR.
  - All other opcodes are illegal.
- Shift amount: t[log2(WIDTH)-1:0]; the upper bits of t are ignored.
- ADD: {cout,result} = s + t, computed at WIDTH+1 bits; overflow = (s[msb]==t[msb]) && (result[msb]!=s[msb]).
- SUB: result = s - t; cout = carry out of s + ~t + 1 (1 when s ≥ t unsigned); overflow = (s[msb]!=t[msb]) && (result[msb]!=s[msb]).
- SLT/SLTU: result = 1 or 0, zero-extended.
- Logic, shift and compare ops: cout = 0, overflow = 0.
- MUL: result = low WIDTH bits of the unsigned product; cout = overflow = (upper WIDTH bits != 0).
- zero = (result == 0); negative = result[msb].
- Illegal opcode: result = 0, err = 1, all other flags 0 (zero included). err = 0 for every legal opcode.
- State machine:
  - States IDLE, MUL, HOLD.
  - IDLE → MUL on accepting opcode 8.
  - MUL → IDLE on the final iteration if the output slot is free; otherwise MUL → HOLD.
  - HOLD → IDLE when the slot frees, loading the result on that edge.
- Output slot is free when !out_valid || out_ready.
- in_ready = reset_n && state==IDLE && slot free (combinational).
- Result registers and flags update only when loading. While out_valid && !out_ready they hold stable.
- out_valid clears on consumption unless a new result loads on the same edge.

## Timing
- Reset (async assert, sync-safe release): state IDLE, out_valid 0, result 0, all flags 0, iteration counter 0.
- Reset during MUL or HOLD aborts the operation; no result is emitted.
- Single-cycle ops: accepted at edge N, out_valid = 1 after edge N. Full throughput is one op per cycle when out_ready is held high.
- MUL: accepted at edge N, one shift-add iteration per edge N+1..N+WIDTH. out_valid = 1 after edge N+WIDTH if the slot is free, otherwise one cycle after the slot frees.
- in_ready stays 0 from acceptance until the MUL result is loaded.
- Simultaneous consumption and load on the same edge: out_valid stays 1 and the new result replaces the old one.

## Configuration
- ALU_MUL_EN defined: opcode 8 legal; MUL and HOLD states, iteration counter and multiplier present.
- ALU_MUL_EN undefined: opcode 8 is illegal (err = 1); FSM reduces to IDLE only; in_ready = slot free.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_AND … OP_NOR);
  - the state enum (IDLE/MUL/HOLD);
  - the flag bundle typedef.
- Sub-module alu_mul_iter holds the shift-add multiplier: accumulator, multiplicand/multiplier shift registers and down-counter. It is instantiated only under ALU_MUL_EN.
- alu_pipe contains the combinational op decode, the handshake FSM and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → after 1 edge: result 0x80000000, overflow 1, negative 1, cout 0, zero 0.
- SUB 5 − 7 → result 0xFFFFFFFE, cout 0, overflow 0. SLT 0xFFFFFFFF, 1 → 1. SLTU 0xFFFFFFFF, 1 → 0. SRA 0x80000000 by t = 4 → 0xF8000000.
- Backpressure: two back-to-back ops, out_ready = 0 for 3 cycles → first result stable and in_ready = 0 throughout. Raise out_ready → second op accepted that edge; its result follows after 1 edge.
- ALU_MUL_EN: MUL 0x00010000 × 0x00010000 → result 0, cout 1, overflow 1, zero 1. out_valid rises exactly 32 edges after acceptance; in_ready = 0 meanwhile.
- Illegal opcode 4'hF (and 4'h8 without ALU_MUL_EN) → result 0, err 1, zero/cout/overflow/negative 0.
- Assert reset_n low at MUL iteration 10 → out_valid 0 immediately. After release: in_ready 1 and no stale result appears.
